snn_reward_layer: RTL and testbench
===================================

// Module: snn_reward_layer
// PURPOSE
//  Parametrised, registered successor to the combinational two-neuron shift network.
//  N_IN inputs drive N_OUT integrate-and-fire neurons through signed shift-weights.
//  Membranes leak between samples, and reward-modulated learning updates the weights.
//  Sits between the pin-level input unpacker and the prediction/readout logic.
//  One sample is processed per transaction, time-multiplexed over inputs.
// PARAMETERS
//  N_IN      4   number of input channels
//  N_OUT     2   number of output neurons
//  IN_W      4   unsigned input width per channel
//  ACC_W     8   unsigned membrane/accumulator width
//  W_W       5   signed shift-weight width (range -2^(W_W-1)..2^(W_W-1)-1)
//  THRESH    1   fire when membrane > THRESH
//  LEAK_SH   1   membrane >>= LEAK_SH at start of each sample
//  LEARN_EN  1   0: skip LEARN state, weights change only via cfg port
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous reset, active-high
//  in_valid     in   1              sample offered
//  in_ready     out  1              high only in IDLE
//  in_data      in   N_IN*IN_W      channel i = in_data[i*IN_W +: IN_W]
//  out_valid    out  1              result held until out_ready
//  out_ready    in   1              result consumer ready
//  out_spikes   out  N_OUT          spike vector of the sample
//  out_winner   out  clog2(N_OUT)   lowest index with max pre-reset membrane
//  reward_valid in   1              reward strobe, consumed only in LEARN
//  reward_pos   in   1              1 = reward (+1), 0 = punish (-1)
//  cfg_we       in   1              weight write strobe
//  cfg_addr     in   clog2(N_IN*N_OUT) synapse j*N_IN+i
//  cfg_wdata    in   W_W            signed weight value
// BEHAVIOUR
//  Reset: state IDLE; all weights, membranes, pre-flags and outputs are 0; in_ready=1.
//  Reset mid-operation aborts the sample and clears weights.
//  FSM: IDLE -> ACCUM -> FIRE -> OUT -> LEARN -> IDLE. OUT goes directly to IDLE when LEARN_EN=0.
//  IDLE: on in_valid, latch in_data, v_j <= v_j >> LEAK_SH, idx <= 0, go ACCUM.
//  cfg_we is honoured only in IDLE; it is ignored in all other states.
//  cfg_we together with in_valid in the same cycle: the write lands and is used for that sample.
//  ACCUM: one input per cycle, idx 0..N_IN-1, all N_OUT neurons in parallel.
//   c = (w>=0) ? x<<w : x>>(-w); saturate c to 2^ACC_W-1 if any bit is lost; right-shift >= IN_W gives 0.
//   v_j <= min(v_j + c, 2^ACC_W-1). After idx = N_IN-1, go FIRE.
//  FIRE (1 cycle): spike_j = v_j > THRESH.
//   Capture out_winner from pre-reset v.
//   v_j <= 0 for spiking neurons.
//   pre_i <= (x_i != 0).
//  OUT: out_valid=1. spikes/winner are stable while out_valid && !out_ready. Leave on out_ready.
//   Latency from in_valid&&in_ready to out_valid: N_IN+2 cycles.
//  LEARN: wait for reward_valid; out_valid=0.
//   On reward_valid, update every synapse with pre_i && spike_j in one cycle:
//   w +1 if reward_pos, else w -1, saturating at W_W limits.
//   All other synapses are unchanged. Then go IDLE.
//   With no spike at all, the reward is still consumed and no weight changes.
//  All outputs are registered; prediction readout is external.
// STRUCTURE
//  snn_pkg: state encoding, shift_sat function, W_MAX/W_MIN constants.
//  Sub-module snn_shift_synapse: combinational saturating signed shift, x/w -> c.
//   Instantiated N_OUT times in ACCUM.
//  Weights are a flat register array [N_OUT*N_IN][W_W].
// TESTING
//  1 rst pulse mid-ACCUM -> next cycle IDLE, in_ready=1, out_valid=0; cfg readback path shows all w=0.
//  2 w[0][0]=+2, x={0,0,0,3} -> out_valid after 6 cycles, v0=12, out_spikes=2'b01, out_winner=0.
//  3 w[0][0]=-2, x0=3 -> c=0, out_spikes=0, out_winner=0; LEARN reward_pos=1 -> weights unchanged.
//  4 w[1][1]=+15, x1=15 -> v1 saturates to 255, out_spikes=2'b10, out_winner=1.
//  5 after test 2, reward_pos=1 -> w[0][0]=3.
//    Preload w=+15 then reward -> stays 15.
//    Preload w=-16 with spike, punish -> stays -16.
//  6 out_ready low 5 cycles -> spikes/winner stable, in_ready=0.
//    cfg_we during OUT -> no weight change.
//    LEARN_EN=0 -> IDLE directly after handshake.

Source files
------------

// File: rtl/snn_reward_layer_pkg.sv
// Shared types and arithmetic helpers for the reward-modulated spiking layer.
package snn_reward_layer_pkg;

  typedef enum logic [2:0] {StIdle, StAccum, StFire, StOut, StLearn} state_e;

  function automatic int w_max(int w_w);
    return (1 << (w_w - 1)) - 1;
  endfunction

  function automatic int w_min(int w_w);
    return -(1 << (w_w - 1));
  endfunction

  // Signed shift of an unsigned sample, clamped to the accumulator range.
  function automatic longint unsigned shift_sat(longint unsigned x, int w, int in_w, int acc_w);
    longint unsigned lim;
    lim = (64'd1 << acc_w) - 64'd1;
    if (w >= 0) begin
      // x < 2^in_w, so any result above lim means bits fell off the accumulator
      if (w >= 64 - in_w) return lim;
      return ((x << w) > lim) ? lim : (x << w);
    end
    return (-w >= in_w) ? 64'd0 : (x >> (-w));
  endfunction

endpackage

// File: rtl/snn_reward_layer_if.sv
// Sample, result, reward and weight-configuration signals of the spiking layer.
interface snn_reward_layer_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned W_W   = 5
);
  localparam int unsigned WinW  = $clog2(N_OUT);
  localparam int unsigned AddrW = $clog2(N_IN * N_OUT);

  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*IN_W-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_OUT-1:0]       out_spikes;
  logic [WinW-1:0]        out_winner;
  logic                   reward_valid;
  logic                   reward_pos;
  logic                   cfg_we;
  logic [AddrW-1:0]       cfg_addr;
  logic signed [W_W-1:0]  cfg_wdata;
  logic signed [W_W-1:0]  cfg_rdata;

  modport master (
    output in_valid, in_data, out_ready, reward_valid, reward_pos, cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, out_valid, out_spikes, out_winner, cfg_rdata
  );

  modport slave (
    input  in_valid, in_data, out_ready, reward_valid, reward_pos, cfg_we, cfg_addr, cfg_wdata,
    output in_ready, out_valid, out_spikes, out_winner, cfg_rdata
  );

endinterface

// File: rtl/snn_reward_layer_shift_synapse.sv
// Combinational synapse: scales one input by a signed power-of-two weight, saturating.
module snn_reward_layer_shift_synapse
  import snn_reward_layer_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned W_W   = 5
) (
  input  logic [IN_W-1:0]        x_i,
  input  logic signed [W_W-1:0]  w_i,
  output logic [ACC_W-1:0]       c_o
);

  always_comb begin
    c_o = ACC_W'(shift_sat(64'(x_i), int'(w_i), int'(IN_W), int'(ACC_W)));
  end

endmodule

// File: rtl/snn_reward_layer.sv
// Integrate-and-fire layer with shift weights, membrane leak and reward-driven learning.
module snn_reward_layer
  import snn_reward_layer_pkg::*;
#(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_OUT    = 2,
  parameter int unsigned IN_W     = 4,
  parameter int unsigned ACC_W    = 8,
  parameter int unsigned W_W      = 5,
  parameter int unsigned THRESH   = 1,
  parameter int unsigned LEAK_SH  = 1,
  parameter bit          LEARN_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  snn_reward_layer_if.slave bus
);

  localparam int unsigned NSyn = N_IN * N_OUT;
  localparam int unsigned IdxW = $clog2(N_IN);
  localparam int unsigned WinW = $clog2(N_OUT);
  localparam logic [ACC_W-1:0]      Thr  = ACC_W'(THRESH);
  localparam logic signed [W_W-1:0] WMax = W_W'(w_max(int'(W_W)));
  localparam logic signed [W_W-1:0] WMin = W_W'(w_min(int'(W_W)));

  state_e                 state_q, state_d;
  logic [N_IN*IN_W-1:0]   x_q, x_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]       v_q [N_OUT];
  logic [ACC_W-1:0]       v_d [N_OUT];
  logic signed [W_W-1:0]  w_q [NSyn];
  logic signed [W_W-1:0]  w_d [NSyn];
  logic [N_IN-1:0]        pre_q, pre_d;
  logic [N_OUT-1:0]       spikes_q, spikes_d;
  logic [WinW-1:0]        winner_q, winner_d;
  logic signed [W_W-1:0]  cfg_rdata_q;

  logic [IN_W-1:0]        x_sel;
  logic signed [W_W-1:0]  w_sel [N_OUT];
  logic [ACC_W-1:0]       c [N_OUT];
  logic [ACC_W:0]         sum;
  logic [ACC_W-1:0]       best_v;
  logic [WinW-1:0]        best_j;

  // Current input channel and its weight into every neuron.
  always_comb begin
    x_sel = '0;
    for (int j = 0; j < N_OUT; j++) w_sel[j] = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == IdxW'(i)) begin
        x_sel = x_q[i*IN_W +: IN_W];
        for (int j = 0; j < N_OUT; j++) w_sel[j] = w_q[j*N_IN + i];
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_syn
    snn_reward_layer_shift_synapse #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .W_W   (W_W)
    ) u_syn (
      .x_i (x_sel),
      .w_i (w_sel[j]),
      .c_o (c[j])
    );
  end

  // Lowest index wins a tie.
  always_comb begin
    best_v = v_q[0];
    best_j = '0;
    for (int j = 1; j < N_OUT; j++) begin
      if (v_q[j] > best_v) begin
        best_v = v_q[j];
        best_j = WinW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StAccum;
      StAccum: if (idx_q == IdxW'(N_IN - 1)) state_d = StFire;
      StFire:  state_d = StOut;
      StOut:   if (bus.out_ready) state_d = LEARN_EN ? StLearn : StIdle;
      StLearn: if (bus.reward_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StOut);
  end

  assign bus.out_spikes = spikes_q;
  assign bus.out_winner = winner_q;
  assign bus.cfg_rdata  = cfg_rdata_q;

  always_comb begin
    x_d      = x_q;
    idx_d    = idx_q;
    v_d      = v_q;
    w_d      = w_q;
    pre_d    = pre_q;
    spikes_d = spikes_q;
    winner_d = winner_q;
    sum      = '0;
    unique case (state_q)
      StIdle: begin
        // A write in the accepting cycle is already visible to this sample's ACCUM.
        if (bus.cfg_we) w_d[bus.cfg_addr] = bus.cfg_wdata;
        if (bus.in_valid) begin
          x_d   = bus.in_data;
          idx_d = '0;
          for (int j = 0; j < N_OUT; j++) v_d[j] = v_q[j] >> LEAK_SH;
        end
      end
      StAccum: begin
        for (int j = 0; j < N_OUT; j++) begin
          sum    = {1'b0, v_q[j]} + {1'b0, c[j]};
          v_d[j] = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
        idx_d = idx_q + IdxW'(1);
      end
      StFire: begin
        winner_d = best_j;
        for (int j = 0; j < N_OUT; j++) begin
          spikes_d[j] = (v_q[j] > Thr);
          if (v_q[j] > Thr) v_d[j] = '0;
        end
        for (int i = 0; i < N_IN; i++) pre_d[i] = (x_q[i*IN_W +: IN_W] != '0);
      end
      StLearn: begin
        if (bus.reward_valid) begin
          for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
              if (pre_q[i] && spikes_q[j]) begin
                if (bus.reward_pos) begin
                  if (w_q[j*N_IN + i] != WMax) w_d[j*N_IN + i] = w_q[j*N_IN + i] + W_W'(1);
                end else begin
                  if (w_q[j*N_IN + i] != WMin) w_d[j*N_IN + i] = w_q[j*N_IN + i] - W_W'(1);
                end
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      idx_q       <= '0;
      v_q         <= '{default: '0};
      w_q         <= '{default: '0};
      pre_q       <= '0;
      spikes_q    <= '0;
      winner_q    <= '0;
      cfg_rdata_q <= '0;
    end else begin
      x_q         <= x_d;
      idx_q       <= idx_d;
      v_q         <= v_d;
      w_q         <= w_d;
      pre_q       <= pre_d;
      spikes_q    <= spikes_d;
      winner_q    <= winner_d;
      cfg_rdata_q <= w_q[bus.cfg_addr];
    end
  end

endmodule

// File: tb/tb_snn_reward_layer.sv
// Bench for snn_reward_layer: hand vectors, multi-cycle corner sequences, random vs model.
module tb_snn_reward_layer;

  localparam int NIn  = 4;
  localparam int NOut = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_reward_layer_if #(.N_IN(4), .N_OUT(2), .IN_W(4), .W_W(5)) bus ();
  snn_reward_layer_if #(.N_IN(4), .N_OUT(2), .IN_W(4), .W_W(5)) bus1 ();

  snn_reward_layer #(.LEARN_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  snn_reward_layer #(.LEARN_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int w_m [8];
  int v_m [2];
  bit pre_m [4];
  bit spk_m [2];
  int win_m;

  typedef struct {
    logic [15:0] data;
    int          w [8];
    int          spk;
    int          win;
    bit          pos;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int contrib(int x, int w);
    int c;
    if (w >= 0) begin
      c = x * (1 << w);
      return (c > 255) ? 255 : c;
    end
    return x / (1 << (-w));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) w_m[k] = 0;
    for (int j = 0; j < NOut; j++) begin v_m[j] = 0; spk_m[j] = 0; end
    for (int i = 0; i < NIn; i++) pre_m[i] = 0;
    win_m = 0;
  endtask

  task automatic model_sample(input logic [15:0] d);
    int best;
    for (int j = 0; j < NOut; j++) begin
      v_m[j] = v_m[j] / 2;
      for (int i = 0; i < NIn; i++) begin
        v_m[j] = v_m[j] + contrib(int'(d[i*4 +: 4]), w_m[j*NIn + i]);
        if (v_m[j] > 255) v_m[j] = 255;
      end
    end
    best = -1;
    for (int j = 0; j < NOut; j++) if (v_m[j] > best) begin best = v_m[j]; win_m = j; end
    for (int j = 0; j < NOut; j++) begin
      spk_m[j] = (v_m[j] > 1);
      if (spk_m[j]) v_m[j] = 0;
    end
    for (int i = 0; i < NIn; i++) pre_m[i] = (d[i*4 +: 4] != 4'd0);
  endtask

  task automatic model_reward(input bit pos);
    for (int j = 0; j < NOut; j++)
      for (int i = 0; i < NIn; i++)
        if (pre_m[i] && spk_m[j]) begin
          if (pos) w_m[j*NIn + i] = (w_m[j*NIn + i] >= 15) ? 15 : w_m[j*NIn + i] + 1;
          else     w_m[j*NIn + i] = (w_m[j*NIn + i] <= -16) ? -16 : w_m[j*NIn + i] - 1;
        end
  endtask

  function automatic int exp_spk();
    return (int'(spk_m[1]) << 1) | int'(spk_m[0]);
  endfunction

  task automatic cfg_write(input int addr, input int val);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'(addr);
    bus.cfg_wdata = 5'(val);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    w_m[addr] = val;
  endtask

  task automatic check_w(input int addr, input string name);
    bus.cfg_addr = 3'(addr);
    @(posedge clk); #1;
    chk(name, int'(bus.cfg_rdata), w_m[addr]);
  endtask

  task automatic check_all_w(input string name);
    for (int k = 0; k < 8; k++) check_w(k, name);
  endtask

  task automatic start_sample(input logic [15:0] d);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_sample(d);
  endtask

  // out_valid is expected N_IN+1 edges after the accepting edge (the N_IN+2-th cycle).
  task automatic wait_out();
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, NIn + 1);
  endtask

  task automatic finish_sample(input bit pos);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("learn_in_ready", int'(bus.in_ready), 0);
    chk("learn_out_valid", int'(bus.out_valid), 0);
    bus.reward_valid = 1'b1;
    bus.reward_pos   = pos;
    @(posedge clk); #1;
    bus.reward_valid = 1'b0;
    model_reward(pos);
    chk("back_to_idle", int'(bus.in_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [15:0] d;

    tbl[0] = '{data: 16'h0003, w: '{2, 0, 0, 0, -2, 0, 0, 0},       spk: 1, win: 0, pos: 1'b1};
    tbl[1] = '{data: 16'h0003, w: '{-2, 0, 0, 0, -2, 0, 0, 0},      spk: 0, win: 0, pos: 1'b1};
    tbl[2] = '{data: 16'h00F0, w: '{0, -4, 0, 0, 0, 15, 0, 0},      spk: 2, win: 1, pos: 1'b1};
    tbl[3] = '{data: 16'h0055, w: '{-16, 1, 0, 0, -16, -16, 0, 0},  spk: 1, win: 0, pos: 1'b0};
    tbl[4] = '{data: 16'h0022, w: '{0, 0, 0, 0, 0, 0, 0, 0},        spk: 3, win: 0, pos: 1'b0};
    tbl[5] = '{data: 16'h1111, w: '{0, 0, 0, 0, 1, 1, 1, 1},        spk: 3, win: 1, pos: 1'b1};
    tbl[6] = '{data: 16'h0001, w: '{0, -4, -4, -4, 1, -4, -4, -4},  spk: 2, win: 1, pos: 1'b0};
    tbl[7] = '{data: 16'hFFFF, w: '{4, 4, 4, 4, -1, -1, -1, -1},    spk: 3, win: 0, pos: 1'b1};

    {bus.in_valid, bus.out_ready, bus.reward_valid, bus.reward_pos, bus.cfg_we} = '0;
    bus.in_data = '0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    {bus1.in_valid, bus1.out_ready, bus1.reward_valid, bus1.reward_pos, bus1.cfg_we} = '0;
    bus1.in_data = '0; bus1.cfg_addr = '0; bus1.cfg_wdata = '0;

    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_spikes", int'(bus.out_spikes), 0);
    chk("rst_winner", int'(bus.out_winner), 0);
    check_all_w("rst_weight");

    // Hand-computed vectors
    foreach (tbl[t]) begin
      for (int k = 0; k < 8; k++) cfg_write(k, tbl[t].w[k]);
      start_sample(tbl[t].data);
      wait_out();
      chk($sformatf("tbl%0d_spikes", t), int'(bus.out_spikes), tbl[t].spk);
      chk($sformatf("tbl%0d_winner", t), int'(bus.out_winner), tbl[t].win);
      finish_sample(tbl[t].pos);
      check_all_w($sformatf("tbl%0d_weight", t));
    end

    // Weight write in the accepting cycle is used by that sample.
    cfg_write(4, -4);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_wdata = 5'd3;
    bus.in_data = 16'h0001; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    w_m[0] = 3;
    model_sample(16'h0001);
    wait_out();
    chk("samecyc_spikes", int'(bus.out_spikes), 1);
    chk("samecyc_winner", int'(bus.out_winner), 0);
    finish_sample(1'b0);
    check_w(0, "samecyc_w00");

    // Back-pressure on the result, ignored cfg write, delayed reward.
    start_sample(16'h0001);
    wait_out();
    for (int n = 0; n < 5; n++) begin
      bus.cfg_we = (n == 2); bus.cfg_addr = 3'd0; bus.cfg_wdata = -5'sd7;
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      chk("stall_spikes", int'(bus.out_spikes), exp_spk());
      chk("stall_winner", int'(bus.out_winner), win_m);
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_out_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("learn_wait_out_valid", int'(bus.out_valid), 0);
      chk("learn_wait_in_ready", int'(bus.in_ready), 0);
    end
    bus.reward_valid = 1'b1; bus.reward_pos = 1'b1;
    @(posedge clk); #1;
    bus.reward_valid = 1'b0;
    model_reward(1'b1);
    check_w(0, "stall_w00");

    // No LEARN state: idle right after the output handshake.
    bus1.in_data = 16'h0003; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("nolearn_latency", lat, NIn + 1);
    chk("nolearn_spikes", int'(bus1.out_spikes), 3);
    chk("nolearn_winner", int'(bus1.out_winner), 0);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    chk("nolearn_in_ready", int'(bus1.in_ready), 1);
    chk("nolearn_out_valid", int'(bus1.out_valid), 0);

    // Asynchronous reset in the middle of ACCUM.
    start_sample(16'hFFFF);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst_spikes", int'(bus.out_spikes), 0);
    check_all_w("midrst_weight");

    // Random traffic against the model
    for (int r = 0; r < 30; r++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--)
        cfg_write($urandom_range(0, 7), int'($urandom_range(0, 31)) - 16);
      d = 16'($urandom) & {{4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}},
                            {4{1'($urandom_range(0, 1))}}, 4'hF};
      start_sample(d);
      wait_out();
      chk("rand_spikes", int'(bus.out_spikes), exp_spk());
      chk("rand_winner", int'(bus.out_winner), win_m);
      finish_sample(1'($urandom_range(0, 1)));
      check_w($urandom_range(0, 7), "rand_weight");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
